// File: rtl/wb_hyperram_arbiter.sv
// Two-master Wishbone classic arbiter in front of the HyperRAM slave port.
// Round-robin grant, per-transfer ack watchdog and a sticky timeout flag.
module wb_hyperram_arbiter #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o,
    input  logic        timeout_clr_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, TOUT} state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        timeout_q, timeout_d;

    logic req0, req1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            last_grant_q <= 1'b1;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            timeout_q    <= timeout_d;
        end
    end

    // last_grant is updated on entry to TOUT, so in TOUT it names the stalled master.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        timeout_d    = timeout_q & ~timeout_clr_i;
        unique case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (req0 && req1) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (s_ack_i || !(state_q == GNT0 ? m0_cyc_i : m1_cyc_i)) begin
                    state_d      = IDLE;
                    cnt_d        = 16'd0;
                    last_grant_d = (state_q == GNT1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = TOUT;
                    cnt_d        = 16'd0;
                    last_grant_d = (state_q == GNT1);
                    timeout_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TOUT: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'd0;
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        m0_ack_o = 1'b0;
        m0_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_dat_o = 32'd0;
        grant_o  = 2'b00;
        unique case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                grant_o  = 2'b01;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                grant_o  = 2'b10;
            end
            TOUT: begin
                if (last_grant_q) begin
                    m1_ack_o = 1'b1;
                    m1_dat_o = TIMEOUT_DATA;
                end else begin
                    m0_ack_o = 1'b1;
                    m0_dat_o = TIMEOUT_DATA;
                end
            end
            default: ;
        endcase
    end

    assign timeout_o = timeout_q;

endmodule
